// File: rtl/jk_ff_pkg.sv
// Shared JK command encoding for the jk_ff block and its per-bit cells.
package jk_ff_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'b00,
      RST  = 2'b01,
      SET  = 2'b10,
      TOG  = 2'b11
   } jk_cmd_e;

   // Packs a {J,K} pair into the command encoding.
   function automatic jk_cmd_e jk_cmd(input logic j, input logic k);
      return jk_cmd_e'({j, k});
   endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single-bit JK flip-flop: one state register, qn derived from it so q/qn never agree.
module jk_cell
   import jk_ff_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qn
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      unique case (jk_cmd(j, k))
         HOLD:    q_d = q_q;
         RST:     q_d = 1'b0;
         SET:     q_d = 1'b1;
         TOG:     q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q  = q_q;
   assign qn = ~q_q;

endmodule

// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flip-flops with synchronous active-low reset.
module jk_ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (J[i]),
         .k     (K[i]),
         .q     (Q[i]),
         .qn    (Qn[i])
      );
   end

endmodule

// File: tb/tb_jk_ff.sv
// Bench for jk_ff: vector table, hand-written timing sequences, random vs. reference model.
module tb_jk_ff;

   logic       clk;
   logic       r1_n, j1, k1;
   logic       q1, qn1;
   logic       r4_n;
   logic [3:0] j4, k4;
   logic [3:0] q4, qn4;

   int checks = 0;
   int passed = 0;

   jk_ff #(.WIDTH(1)) u1 (
      .clk   (clk),
      .rst_n (r1_n),
      .J     (j1),
      .K     (k1),
      .Q     (q1),
      .Qn    (qn1)
   );

   jk_ff #(.WIDTH(4)) u4 (
      .clk   (clk),
      .rst_n (r4_n),
      .J     (j4),
      .K     (k4),
      .Q     (q4),
      .Qn    (qn4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic rst_n;
      logic j;
      logic k;
      logic q;
   } vec_t;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Characteristic equation Q+ = J&~Q | ~K&Q, reset dominant.
   function automatic logic [3:0] model(input logic rst_n, input logic [3:0] j,
                                        input logic [3:0] k, input logic [3:0] q);
      if (!rst_n) return 4'b0000;
      return (j & ~q) | (~k & q);
   endfunction

   vec_t       tbl [18];
   int         rises;
   logic       prev;
   logic [3:0] m1, m4;

   initial begin
      r1_n = 1'b1; j1 = 1'b0; k1 = 1'b0;
      r4_n = 1'b1; j4 = '0;   k4 = '0;

      // reset with J=K=1, release with hold, truth table, then 8 toggles
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 9; i < 17; i++) begin
         tbl[i] = '{1'b1, 1'b1, 1'b1, ((i - 9) % 2 == 0) ? 1'b1 : 1'b0};
      end
      tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0};

      #1;
      rises = 0;
      prev  = 1'b0;
      for (int i = 0; i < 18; i++) begin
         r1_n = tbl[i].rst_n;
         j1   = tbl[i].j;
         k1   = tbl[i].k;
         tick();
         chk($sformatf("tbl%0d_q", i), {3'b0, q1}, {3'b0, tbl[i].q});
         chk($sformatf("tbl%0d_qn", i), {3'b0, qn1}, {3'b0, {~tbl[i].q}});
         if (i >= 9 && i < 17) begin
            if (q1 === 1'b1 && prev === 1'b0) rises++;
            prev = q1;
         end
      end
      chk("div2_rises", rises[3:0], 4'd4);

      // synchronous reset: drop rst_n mid-cycle with Q=1
      r1_n = 1'b1; j1 = 1'b1; k1 = 1'b0;
      tick();
      chk("sr_set", {3'b0, q1}, 4'b0001);
      j1 = 1'b0;
      #2 r1_n = 1'b0;
      #1 chk("sr_midcycle_hold", {3'b0, q1}, 4'b0001);
      tick();
      chk("sr_applied", {3'b0, q1}, 4'b0000);
      chk("sr_applied_qn", {3'b0, qn1}, 4'b0001);
      r1_n = 1'b1; j1 = 1'b1; k1 = 1'b0;
      tick();
      chk("sr_release_set", {3'b0, q1}, 4'b0001);

      // mid-cycle J/K glitches restored before the edge
      j1 = 1'b0; k1 = 1'b0;
      #2 begin j1 = 1'b0; k1 = 1'b1; end
      #2 begin j1 = 1'b1; k1 = 1'b1; end
      #2 chk("mid_glitch_q", {3'b0, q1}, 4'b0001);
      j1 = 1'b0; k1 = 1'b0;
      tick();
      chk("mid_after_edge", {3'b0, q1}, 4'b0001);

      // WIDTH=4 directed
      r4_n = 1'b0; j4 = 4'b1111; k4 = 4'b1111;
      tick();
      chk("w4_reset_q", q4, 4'b0000);
      chk("w4_reset_qn", qn4, 4'b1111);
      r4_n = 1'b1; j4 = 4'b1010; k4 = 4'b0110;
      tick();
      chk("w4_mixed", q4, 4'b1010);
      j4 = 4'b1111; k4 = 4'b1111;
      tick();
      chk("w4_toggle", q4, 4'b0101);
      chk("w4_toggle_qn", qn4, 4'b1010);

      // random against the model, both instances
      m1 = {3'b0, q1};
      m4 = q4;
      for (int n = 0; n < 300; n++) begin
         r1_n = ($urandom_range(0, 9) != 0);
         r4_n = ($urandom_range(0, 9) != 0);
         j1   = 1'($urandom);
         k1   = 1'($urandom);
         j4   = 4'($urandom);
         k4   = 4'($urandom);
         m1   = model(r1_n, {3'b0, j1}, {3'b0, k1}, m1) & 4'b0001;
         m4   = model(r4_n, j4, k4, m4);
         tick();
         chk("rnd_w1_q", {3'b0, q1}, m1);
         chk("rnd_w1_qn", {3'b0, qn1}, {3'b0, {~m1[0]}});
         chk("rnd_w4_q", q4, m4);
         chk("rnd_w4_qn", qn4, ~m4);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
